// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one SRAM-style port between instruction fetch and data access.
// Data has priority; a saturating starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  inst_req_valid,
    output logic                  inst_req_ready,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_rsp_valid,
    output logic [DATA_W-1:0]     inst_rdata,
    input  logic                  data_req_valid,
    output logic                  data_req_ready,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic                  data_wen,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_rsp_valid,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;   // 1 = fetch owns the transaction
    logic                  drop_q, drop_d;
    logic [3:0]            starve_q, starve_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [DATA_W/8-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]     inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]     data_rdata_q, data_rdata_d;
    logic                  inst_rsp_q, inst_rsp_d;
    logic                  data_rsp_q, data_rsp_d;

    logic                  starve_hit;
    logic                  grant_inst;
    logic                  grant_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            drop_q       <= 1'b0;
            starve_q     <= '0;
            mem_addr_q   <= '0;
            mem_wen_q    <= 1'b0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_rsp_q   <= 1'b0;
            data_rsp_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            starve_q     <= starve_d;
            mem_addr_q   <= mem_addr_d;
            mem_wen_q    <= mem_wen_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_rsp_q   <= inst_rsp_d;
            data_rsp_q   <= data_rsp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        drop_d       = drop_q;
        starve_d     = starve_q;
        mem_addr_d   = mem_addr_q;
        mem_wen_d    = mem_wen_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_rsp_d   = 1'b0;
        data_rsp_d   = 1'b0;

        starve_hit = (starve_q == LIMIT);
        grant_inst = (state_q == S_IDLE) && inst_req_valid && !flush && (!data_req_valid || starve_hit);
        grant_data = (state_q == S_IDLE) && data_req_valid && !grant_inst;

        case (state_q)
            S_IDLE: begin
                if (grant_inst) begin
                    state_d     = S_REQ;
                    owner_d     = 1'b1;
                    mem_addr_d  = inst_addr;
                    mem_wen_d   = 1'b0;
                    mem_wstrb_d = '0;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end else if (grant_data) begin
                    state_d     = S_REQ;
                    owner_d     = 1'b0;
                    mem_addr_d  = data_addr;
                    mem_wen_d   = data_wen;
                    mem_wstrb_d = data_wstrb;
                    mem_wdata_d = data_wdata;
                    if (!inst_req_valid) begin
                        starve_d = '0;
                    end else if (!starve_hit) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            S_REQ: begin
                if (flush && owner_q) begin
                    drop_d = 1'b1;
                end
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush && owner_q) begin
                    drop_d = 1'b1;
                end
                if (mem_rsp_valid) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                    // A flush arriving with the response still kills it.
                    if (owner_q) begin
                        inst_rdata_d = mem_rdata;
                        inst_rsp_d   = !(drop_q || flush);
                    end else begin
                        data_rdata_d = mem_rdata;
                        data_rsp_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Readies are gated by reset so nothing is accepted while reset is held.
    assign inst_req_ready = grant_inst && reset;
    assign data_req_ready = grant_data && reset;
    assign mem_req_valid  = (state_q == S_REQ);
    assign mem_addr       = mem_addr_q;
    assign mem_wen        = mem_wen_q;
    assign mem_wstrb      = mem_wstrb_q;
    assign mem_wdata      = mem_wdata_q;
    assign inst_rsp_valid = inst_rsp_q;
    assign inst_rdata     = inst_rdata_q;
    assign data_rsp_valid = data_rsp_q;
    assign data_rdata     = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for grant order, latched fields, responses and reset behaviour.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        inst_req_valid = 1'b0;
    logic        inst_req_ready;
    logic [31:0] inst_addr = '0;
    logic        inst_rsp_valid;
    logic [31:0] inst_rdata;
    logic        data_req_valid = 1'b0;
    logic        data_req_ready;
    logic [31:0] data_addr = '0;
    logic        data_wen = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_wdata = '0;
    logic        data_rsp_valid;
    logic [31:0] data_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    rdly = 0;
    int    wdly = 0;
    int    cyc = 0;
    string glog = "";
    int    i_pulses = 0;
    int    d_pulses = 0;
    logic [31:0] last_irdata = '0;
    int    i_grant_cyc = -1;
    int    d_pulse_cyc = -2;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .inst_addr(inst_addr),
        .inst_rsp_valid(inst_rsp_valid), .inst_rdata(inst_rdata),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready), .data_addr(data_addr),
        .data_wen(data_wen), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_rsp_valid(data_rsp_valid), .data_rdata(data_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic chks(input string nm, input string act, input string exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got \"%s\", expected \"%s\"", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0100: memf = 32'h0000_0013;
            32'h0000_0300: memf = 32'h00A0_0093;
            default:       memf = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Memory responder: ready after rdly stall cycles, response wdly cycles after acceptance.
    initial begin
        int rs;
        int cnt;
        rs = 0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (!reset) begin
                rs = 0;
                continue;
            end
            if (rs == 0 && mem_req_valid) begin
                rs = 1;
                cnt = rdly;
            end
            if (rs == 1) begin
                if (cnt == 0) begin
                    mem_req_ready = 1'b1;
                    rs = 2;
                    cnt = wdly;
                end else cnt--;
            end else if (rs == 2) begin
                if (cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata = memf(mem_addr);
                    rs = 0;
                end else cnt--;
            end
        end
    end

    // Reference model: one transaction at a time, tracked as busy / accepted-by-memory flags.
    initial begin
        bit          m_busy, m_acc, m_own_i, m_drop, m_dstore, m_irsp, m_drsp;
        int          m_starve;
        logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
        logic        m_wen;
        logic [3:0]  m_wstrb;
        bit          e_ir, e_dr, e_mv;
        m_busy = 0; m_acc = 0; m_own_i = 0; m_drop = 0; m_dstore = 0; m_irsp = 0; m_drsp = 0;
        m_starve = 0; m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0; m_wen = 0; m_wstrb = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                chk("rst_inst_req_ready", 64'(inst_req_ready), 64'(0));
                chk("rst_data_req_ready", 64'(data_req_ready), 64'(0));
                chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
                chk("rst_rsp_valids", 64'({inst_rsp_valid, data_rsp_valid}), 64'(0));
                chk("rst_mem_fields", 64'(mem_addr | mem_wdata | 32'(mem_wstrb) | 32'(mem_wen)), 64'(0));
                chk("rst_rdata", 64'(inst_rdata | data_rdata), 64'(0));
                m_busy = 0; m_acc = 0; m_drop = 0; m_starve = 0; m_irsp = 0; m_drsp = 0;
                continue;
            end
            e_ir = !m_busy && inst_req_valid && !flush && (!data_req_valid || m_starve == LIMIT);
            e_dr = !m_busy && data_req_valid && !e_ir;
            e_mv = m_busy && !m_acc;
            chk("inst_req_ready", 64'(inst_req_ready), 64'(e_ir));
            chk("data_req_ready", 64'(data_req_ready), 64'(e_dr));
            chk("mem_req_valid", 64'(mem_req_valid), 64'(e_mv));
            chk("inst_rsp_valid", 64'(inst_rsp_valid), 64'(m_irsp));
            chk("data_rsp_valid", 64'(data_rsp_valid), 64'(m_drsp));
            if (m_busy) begin
                chk("mem_addr", 64'(mem_addr), 64'(m_addr));
                chk("mem_wen", 64'(mem_wen), 64'(m_wen));
                chk("mem_wstrb", 64'(mem_wstrb), 64'(m_wstrb));
                if (!m_own_i) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            end
            if (m_irsp) chk("inst_rdata", 64'(inst_rdata), 64'(m_irdata));
            if (m_drsp && !m_dstore) chk("data_rdata", 64'(data_rdata), 64'(m_drdata));

            if (inst_req_ready) begin glog = {glog, "I"}; i_grant_cyc = cyc; end
            if (data_req_ready) glog = {glog, "D"};
            if (inst_rsp_valid) begin i_pulses++; last_irdata = inst_rdata; end
            if (data_rsp_valid) begin d_pulses++; d_pulse_cyc = cyc; end

            m_irsp = 0;
            m_drsp = 0;
            if (!m_busy) begin
                if (e_ir) begin
                    m_busy = 1; m_acc = 0; m_own_i = 1; m_addr = inst_addr; m_wen = 0; m_wstrb = '0;
                    m_starve = 0;
                end else if (e_dr) begin
                    m_busy = 1; m_acc = 0; m_own_i = 0; m_addr = data_addr; m_wen = data_wen;
                    m_wstrb = data_wstrb; m_wdata = data_wdata; m_dstore = data_wen;
                    m_starve = inst_req_valid ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
                end
            end else begin
                if (flush && m_own_i) m_drop = 1;
                if (!m_acc) begin
                    if (mem_req_ready) m_acc = 1;
                end else if (mem_rsp_valid) begin
                    m_busy = 0;
                    if (m_own_i) begin m_irdata = mem_rdata; m_irsp = !m_drop; end
                    else begin m_drdata = mem_rdata; m_drsp = 1; end
                    m_drop = 0;
                end
            end
        end
    end

    task automatic step(input bit keep_i, input bit keep_d, output bit gi, output bit gd);
        @(negedge clk);
        gi = inst_req_ready;
        gd = data_req_ready;
        @(posedge clk);
        #1;
        if (gi && !keep_i) inst_req_valid = 1'b0;
        if (gd && !keep_d) data_req_valid = 1'b0;
    endtask

    task automatic clear_logs();
        glog = "";
        i_pulses = 0;
        d_pulses = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gi, gd, got;
        int reqc;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) step(0, 0, gi, gd);

        // Single fetch
        clear_logs();
        rdly = 0; wdly = 1;
        inst_addr = 32'h100; inst_req_valid = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin step(0, 0, gi, gd); got = gi; end
        chk("fetch_granted", 64'(got), 64'(1));
        chk("fetch_mem_req_valid", 64'(mem_req_valid), 64'(1));
        chk("fetch_mem_addr", 64'(mem_addr), 64'h100);
        chk("fetch_mem_wen", 64'(mem_wen), 64'(0));
        chk("fetch_mem_wstrb", 64'(mem_wstrb), 64'(0));
        repeat (8) step(0, 0, gi, gd);
        chks("fetch_grants", glog, "I");
        chk("fetch_pulses", 64'(i_pulses), 64'(1));
        chk("fetch_rdata", 64'(last_irdata), 64'h13);
        chk("fetch_no_data_rsp", 64'(d_pulses), 64'(0));

        // Simultaneous fetch and load
        clear_logs();
        rdly = 0; wdly = 0;
        inst_addr = 32'h200; inst_req_valid = 1'b1;
        data_addr = 32'h8000; data_wen = 1'b0; data_req_valid = 1'b1;
        repeat (14) step(0, 0, gi, gd);
        chks("simul_grants", glog, "DI");
        chk("simul_fetch_with_pulse", 64'(i_grant_cyc), 64'(d_pulse_cyc));
        chk("simul_pulses", 64'({i_pulses[7:0], d_pulses[7:0]}), 64'h0101);

        // Starvation
        clear_logs();
        inst_addr = 32'h240; inst_req_valid = 1'b1;
        data_addr = 32'h8004; data_req_valid = 1'b1;
        for (int k = 0; k < 120 && glog.len() < 11; k++) step(1, 1, gi, gd);
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        repeat (8) step(0, 0, gi, gd);
        chks("starve_order", glog, "DDDDIDDDDID");

        // Store with stalled memory accept
        clear_logs();
        rdly = 3; wdly = 1; reqc = 0;
        data_addr = 32'h9000; data_wen = 1'b1; data_wstrb = 4'h3; data_wdata = 32'hDEADBEEF;
        data_req_valid = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step(0, 0, gi, gd);
            if (mem_req_valid) begin
                reqc++;
                chk("store_addr", 64'(mem_addr), 64'h9000);
                chk("store_wen", 64'(mem_wen), 64'(1));
                chk("store_wstrb", 64'(mem_wstrb), 64'h3);
                chk("store_wdata", 64'(mem_wdata), 64'hDEADBEEF);
            end
        end
        data_wen = 1'b0; data_wstrb = '0;
        chk("store_req_cycles", 64'(reqc), 64'(4));
        chk("store_ack", 64'(d_pulses), 64'(1));

        // Flush of a fetch in WAIT, then a normal fetch
        clear_logs();
        rdly = 0; wdly = 2;
        inst_addr = 32'h400; inst_req_valid = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin step(0, 0, gi, gd); got = gi; end
        chk("flush_fetch_granted", 64'(got), 64'(1));
        step(0, 0, gi, gd);
        chk("flush_in_wait", 64'(mem_req_valid), 64'(0));
        flush = 1'b1;
        step(0, 0, gi, gd);
        flush = 1'b0;
        repeat (6) step(0, 0, gi, gd);
        chk("flush_suppressed", 64'(i_pulses), 64'(0));
        rdly = 1; wdly = 0;
        inst_addr = 32'h300; inst_req_valid = 1'b1;
        repeat (10) step(0, 0, gi, gd);
        chks("flush_grants", glog, "II");
        chk("after_flush_pulse", 64'(i_pulses), 64'(1));
        chk("after_flush_rdata", 64'(last_irdata), 64'h00A00093);

        // Flush in IDLE blocks fetch only; flush during a data transaction is harmless
        clear_logs();
        rdly = 0; wdly = 0;
        inst_addr = 32'h500; inst_req_valid = 1'b1; flush = 1'b1;
        step(1, 0, gi, gd);
        chk("idle_flush_blocks_fetch", 64'(gi), 64'(0));
        data_addr = 32'hA000; data_req_valid = 1'b1;
        step(1, 0, gi, gd);
        chk("idle_flush_data_granted", 64'(gd), 64'(1));
        step(1, 0, gi, gd);
        flush = 1'b0;
        repeat (10) step(0, 0, gi, gd);
        chks("idle_flush_grants", glog, "DI");
        chk("idle_flush_pulses", 64'({i_pulses[7:0], d_pulses[7:0]}), 64'h0101);

        // Asynchronous reset mid-REQ, then counter must restart from zero
        clear_logs();
        inst_addr = 32'h600; inst_req_valid = 1'b1;
        data_addr = 32'hB000; data_req_valid = 1'b1;
        for (int k = 0; k < 40 && glog.len() < 2; k++) step(1, 1, gi, gd);
        rdly = 5;
        for (int k = 0; k < 60 && glog.len() < 3; k++) step(1, 1, gi, gd);
        chks("pre_reset_grants", glog, "DDD");
        chk("pre_reset_in_req", 64'(mem_req_valid), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("async_rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("async_rst_readies", 64'({inst_req_ready, data_req_ready}), 64'(0));
        chk("async_rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("async_rst_mem_wen_wstrb", 64'({mem_wen, mem_wstrb}), 64'(0));
        chk("async_rst_mem_wdata", 64'(mem_wdata), 64'(0));
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        clear_logs();
        rdly = 0; wdly = 0;
        inst_req_valid = 1'b1; data_req_valid = 1'b1;
        for (int k = 0; k < 60 && glog.len() < 5; k++) step(1, 1, gi, gd);
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        repeat (8) step(0, 0, gi, gd);
        chks("post_reset_order", glog, "DDDDI");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
